// File: rtl/alu16_flags_if.sv
// rtl/alu16_flags_if.sv - operand/opcode request and result/flag bundle for alu16_flags
interface alu16_flags_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH-1:0] z;
  logic             s;
  logic             zr;
  logic             cy;
  logic             p;
  logic             v;
  logic             out_valid;

  modport master (
    output in_valid, op, x, y, cin,
    input  z, s, zr, cy, p, v, out_valid
  );

  modport slave (
    input  in_valid, op, x, y, cin,
    output z, s, zr, cy, p, v, out_valid
  );
endinterface

// File: rtl/alu16_flags.sv
// rtl/alu16_flags.sv - registered ALU with sign/zero/carry/parity/overflow flags
// Define ALU_SAT_EN to clamp signed overflow on ADD/ADC/SUB/SBB/INC/DEC.
module alu16_flags #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu16_flags_if.slave alu
);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SBB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_SAR   = 4'hA;
  localparam logic [3:0] OP_INC   = 4'hB;
  localparam logic [3:0] OP_DEC   = 4'hC;
  localparam logic [3:0] OP_PASSX = 4'hD;
  localparam logic [3:0] OP_PASSY = 4'hE;

  logic [WIDTH-1:0] b_opd;
  logic             c_opd;
  logic             is_sub;
  logic             is_arith;
  logic [WIDTH:0]   sum_full;
  logic             ovf_arith;
  logic [WIDTH-1:0] z_new;
  logic             cy_new;
  logic             v_new;

  logic [WIDTH-1:0] z_d, z_q;
  logic             s_d, s_q;
  logic             zr_d, zr_q;
  logic             cy_d, cy_q;
  logic             p_d, p_q;
  logic             v_d, v_q;
  logic             out_valid_d, out_valid_q;

  // INC/DEC share the adder with an implicit second operand of 1.
  always_comb begin
    b_opd    = alu.y;
    c_opd    = 1'b0;
    is_sub   = 1'b0;
    is_arith = 1'b0;
    case (alu.op)
      OP_ADD: is_arith = 1'b1;
      OP_ADC: begin is_arith = 1'b1; c_opd = alu.cin; end
      OP_SUB: begin is_arith = 1'b1; is_sub = 1'b1; end
      OP_SBB: begin is_arith = 1'b1; is_sub = 1'b1; c_opd = alu.cin; end
      OP_INC: begin is_arith = 1'b1; b_opd = {{(WIDTH-1){1'b0}}, 1'b1}; end
      OP_DEC: begin is_arith = 1'b1; is_sub = 1'b1; b_opd = {{(WIDTH-1){1'b0}}, 1'b1}; end
      default: ;
    endcase
  end

  always_comb begin
    if (is_sub) begin
      sum_full  = {1'b0, alu.x} - {1'b0, b_opd} - {{WIDTH{1'b0}}, c_opd};
      ovf_arith = (alu.x[MSB] != b_opd[MSB]) && (sum_full[MSB] != alu.x[MSB]);
    end else begin
      sum_full  = {1'b0, alu.x} + {1'b0, b_opd} + {{WIDTH{1'b0}}, c_opd};
      ovf_arith = (alu.x[MSB] == b_opd[MSB]) && (sum_full[MSB] != alu.x[MSB]);
    end
  end

  always_comb begin
    z_new  = '0;
    cy_new = 1'b0;
    v_new  = 1'b0;
    if (is_arith) begin
      z_new  = sum_full[WIDTH-1:0];
      cy_new = sum_full[WIDTH];
      v_new  = ovf_arith;
`ifdef ALU_SAT_EN
      // Overflow direction always follows the sign of x for both add and subtract.
      if (ovf_arith) begin
        z_new = alu.x[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end else begin
      case (alu.op)
        OP_AND:   z_new = alu.x & alu.y;
        OP_OR:    z_new = alu.x | alu.y;
        OP_XOR:   z_new = alu.x ^ alu.y;
        OP_NOT:   z_new = ~alu.x;
        OP_SHL: begin
          z_new  = {alu.x[MSB-1:0], 1'b0};
          cy_new = alu.x[MSB];
          v_new  = alu.x[MSB] ^ alu.x[MSB-1];
        end
        OP_SHR: begin
          z_new  = {1'b0, alu.x[MSB:1]};
          cy_new = alu.x[0];
        end
        OP_SAR: begin
          z_new  = {alu.x[MSB], alu.x[MSB:1]};
          cy_new = alu.x[0];
        end
        OP_PASSX: z_new = alu.x;
        OP_PASSY: z_new = alu.y;
        default:  z_new = '0;
      endcase
    end
  end

  always_comb begin
    z_d         = z_q;
    s_d         = s_q;
    zr_d        = zr_q;
    cy_d        = cy_q;
    p_d         = p_q;
    v_d         = v_q;
    out_valid_d = alu.in_valid;
    if (alu.in_valid) begin
      z_d  = z_new;
      s_d  = z_new[MSB];
      zr_d = (z_new == '0);
      cy_d = cy_new;
      p_d  = ~^z_new;
      v_d  = v_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= '0;
      s_q         <= 1'b0;
      zr_q        <= 1'b0;
      cy_q        <= 1'b0;
      p_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      z_q         <= z_d;
      s_q         <= s_d;
      zr_q        <= zr_d;
      cy_q        <= cy_d;
      p_q         <= p_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign alu.z         = z_q;
  assign alu.s         = s_q;
  assign alu.zr        = zr_q;
  assign alu.cy        = cy_q;
  assign alu.p         = p_q;
  assign alu.v         = v_q;
  assign alu.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu16_flags.sv
// tb/tb_alu16_flags.sv - randomized and directed self-checking bench for alu16_flags
module tb_alu16_flags;
  localparam int W    = 16;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  int   exp_z, exp_cy, exp_v;

  alu16_flags_if #(.WIDTH(W)) bus ();

  alu16_flags #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int want);
    total++;
    if (got !== 32'(want)) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: integer arithmetic with a signed range test for overflow.
  function automatic void model(input int op, input int xu, input int yu, input int c,
                                output int z, output int cy, output int v);
    int  sx, sy, r, sr;
    bit  arith;
    sx = (xu >= HALF) ? xu - FULL : xu;
    sy = (yu >= HALF) ? yu - FULL : yu;
    r = 0; sr = 0; arith = 0; z = 0; cy = 0; v = 0;
    case (op)
      0:  begin arith = 1; r = xu + yu;     sr = sx + sy;     cy = int'(r >= FULL); end
      1:  begin arith = 1; r = xu + yu + c; sr = sx + sy + c; cy = int'(r >= FULL); end
      2:  begin arith = 1; r = xu - yu;     sr = sx - sy;     cy = int'(r < 0); end
      3:  begin arith = 1; r = xu - yu - c; sr = sx - sy - c; cy = int'(r < 0); end
      4:  z = xu & yu;
      5:  z = xu | yu;
      6:  z = xu ^ yu;
      7:  z = (FULL - 1) - xu;
      8:  begin
            z  = (xu * 2) % FULL;
            cy = int'(xu >= HALF);
            v  = int'((sx * 2 > HALF - 1) || (sx * 2 < -HALF));
          end
      9:  begin z = xu / 2; cy = xu % 2; end
      10: begin z = xu / 2 + ((xu >= HALF) ? HALF : 0); cy = xu % 2; end
      11: begin arith = 1; r = xu + 1; sr = sx + 1; cy = int'(r >= FULL); end
      12: begin arith = 1; r = xu - 1; sr = sx - 1; cy = int'(r < 0); end
      13: z = xu;
      14: z = yu;
      default: z = 0;
    endcase
    if (arith) begin
      v = int'((sr > HALF - 1) || (sr < -HALF));
      z = ((r % FULL) + FULL) % FULL;
`ifdef ALU_SAT_EN
      if (v != 0) z = (sr > 0) ? HALF - 1 : HALF;
`endif
    end
  endfunction

  function automatic int pick_operand();
    case ($urandom_range(0, 6))
      0:       return 0;
      1:       return 1;
      2:       return HALF - 1;
      3:       return HALF;
      4:       return FULL - 1;
      default: return int'($urandom_range(0, FULL - 1));
    endcase
  endfunction

  task automatic check_outputs(input string tag, input int ez, input int ecy, input int ev, input int eov);
    check({tag, ".z"},  bus.z,         ez);
    check({tag, ".s"},  bus.s,         int'(ez >= HALF));
    check({tag, ".zr"}, bus.zr,        int'(ez == 0));
    check({tag, ".cy"}, bus.cy,        ecy);
    check({tag, ".p"},  bus.p,         int'(($countones(ez) % 2) == 0));
    check({tag, ".v"},  bus.v,         ev);
    check({tag, ".ov"}, bus.out_valid, eov);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".z"},  bus.z,         0);
    check({tag, ".s"},  bus.s,         0);
    check({tag, ".zr"}, bus.zr,        0);
    check({tag, ".cy"}, bus.cy,        0);
    check({tag, ".p"},  bus.p,         0);
    check({tag, ".v"},  bus.v,         0);
    check({tag, ".ov"}, bus.out_valid, 0);
  endtask

  task automatic drive(input int op, input int xv, input int yv, input int c);
    bus.in_valid = 1'b1;
    bus.op       = 4'(op);
    bus.x        = 16'(xv);
    bus.y        = 16'(yv);
    bus.cin      = 1'(c);
  endtask

  task automatic run_op(input int op, input int xv, input int yv, input int c);
    @(negedge clk);
    drive(op, xv, yv, c);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model(op, xv, yv, c, exp_z, exp_cy, exp_v);
  endtask

  task automatic directed(input string tag, input int op, input int xv, input int yv, input int c,
                          input int ez, input int ecy, input int ev);
    run_op(op, xv, yv, c);
    check_outputs(tag, ez, ecy, ev, 1);
  endtask

  initial begin
    int ops [4];
    int xs  [4];
    int ys  [4];
    int cs  [4];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op  = '0;
    bus.x   = '0;
    bus.y   = '0;
    bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_SAT_EN
    directed("add_ovf", 0, 'h8FFF, 'h8000, 0, 'h8000, 1, 1);
`else
    directed("add_ovf", 0, 'h8FFF, 'h8000, 0, 'h0FFF, 1, 1);
`endif
    directed("add_zero", 0, 'hFFFE, 'h0002, 0, 'h0000, 1, 0);
    directed("add_ones", 0, 'hAAAA, 'h5555, 0, 'hFFFF, 0, 0);
    directed("sub_bor",  2, 'h0001, 'h0002, 0, 'hFFFF, 1, 0);
`ifdef ALU_SAT_EN
    directed("sbb_ovf",  3, 'h8000, 'h0000, 1, 'h8000, 0, 1);
`else
    directed("sbb_ovf",  3, 'h8000, 'h0000, 1, 'h7FFF, 0, 1);
`endif
    directed("shl",      8, 'hC001, 'h1234, 0, 'h8002, 1, 0);
    directed("sar",     10, 'h8001, 'h0000, 0, 'hC000, 1, 0);
    directed("and",      4, 'hF0F0, 'h0FF0, 0, 'h00F0, 0, 0);
    directed("rsvd",    15, 'h1234, 'h5678, 1, 'h0000, 0, 0);

    // Idle cycles: outputs keep the last result while inputs wander.
    run_op(0, 'h1234, 'h0F0F, 0);
    for (int i = 0; i < 3; i++) begin
      bus.op = 4'($urandom_range(0, 15));
      bus.x  = 16'($urandom);
      bus.y  = 16'($urandom);
      @(posedge clk);
      #1;
      check_outputs("hold", exp_z, exp_cy, exp_v, 0);
    end

    for (int i = 0; i < 4; i++) begin
      ops[i] = int'($urandom_range(0, 15));
      xs[i]  = pick_operand();
      ys[i]  = pick_operand();
      cs[i]  = int'($urandom_range(0, 1));
    end
    @(negedge clk);
    drive(ops[0], xs[0], ys[0], cs[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) drive(ops[i+1], xs[i+1], ys[i+1], cs[i+1]);
      else bus.in_valid = 1'b0;
      model(ops[i], xs[i], ys[i], cs[i], exp_z, exp_cy, exp_v);
      check_outputs("b2b", exp_z, exp_cy, exp_v, 1);
    end
    @(posedge clk);
    #1;
    check("b2b_end.ov", bus.out_valid, 0);

    for (int i = 0; i < 300; i++) begin
      int op, xv, yv, c;
      op = int'($urandom_range(0, 15));
      xv = pick_operand();
      yv = pick_operand();
      c  = int'($urandom_range(0, 1));
      run_op(op, xv, yv, c);
      check_outputs($sformatf("rand_op%0d", op), exp_z, exp_cy, exp_v, 1);
    end

    // Reset between edges with a request pending: it must be dropped.
    run_op(0, 'h0001, 'h0001, 0);
    @(negedge clk);
    drive(0, 'h0100, 'h0011, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(posedge clk);
    #1;
    check_cleared("rst_edge");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
